m72_rom_loader: RTL and testbench
=================================

Name: m72_rom_loader

Overview:
- Consumes the MiSTer ioctl ROM download stream and distributes it into board memories using the region table `m72_pkg::LOAD_REGIONS`.
- Walks the six regions in order: CPU ROM, sprite, BG A, BG B, MCU, samples.
- SDRAM regions are written as 16-bit words through a req/ack handshake; BRAM regions are written as single bytes.
- Sits between the HPS ioctl interface and the SDRAM controller / BRAM write ports.

Parameters:
- NUM_REGIONS, 6, number of entries of LOAD_REGIONS consumed, in order.
- BRAM_ADDR_W, 20, width of bram_addr.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- ioctl_download  in  1  high while a ROM download is in progress
- ioctl_wr  in  1  one-cycle strobe: ioctl_dout is valid
- ioctl_dout  in  8  download byte
- ioctl_wait  out  1  backpressure to HPS; no ioctl_wr is issued while high
- sdr_addr  out  25  SDRAM byte address, bit 0 always 0
- sdr_data  out  16  write word, even byte on [7:0]
- sdr_be  out  2  byte enables
- sdr_req  out  1  write request, held until ack
- sdr_ack  in  1  one-cycle acknowledge from the SDRAM controller
- bram_addr  out  BRAM_ADDR_W  byte offset within the region
- bram_data  out  8  BRAM write byte
- bram_cs  out  2  region bram_cs, valid with bram_wr
- bram_wr  out  1  one-cycle BRAM write strobe
- region_idx  out  3  current region index
- load_done  out  1  all regions consumed; sticky until the next download starts

Behaviour:
- Reset: state IDLE; all outputs 0; byte offset, header counter and pending byte cleared.
  - Reset mid-download abandons everything immediately, including an in-flight sdr_req.
- Stream format: each region is a 4-byte big-endian length header followed by that many data bytes.
  - Only the low 25 bits of the length are used.
  - Bytes after region NUM_REGIONS-1 are ignored.
- States:
  - IDLE: on a rising edge of ioctl_download: region_idx=0, load_done=0, go to HDR.
  - HDR: capture 4 bytes MSB-first, one per ioctl_wr.
    - After byte 4: if length==0, advance the region (HDR again, or DONE if last); otherwise go to DATA with offset=0.
  - DATA, per ioctl_wr byte B at offset O (the region is SDRAM when its bram_cs==0):
    - BRAM region: next cycle bram_wr=1, bram_addr=O[BRAM_ADDR_W-1:0], bram_data=B, bram_cs=region bram_cs.
    - SDRAM region, O even: latch B as the pending low byte.
    - SDRAM region, O odd: next cycle assert sdr_req with sdr_data={B,pending}, sdr_be=2'b11, sdr_addr=base_addr+A, then go to SDR_WAIT.
    - A = O with bit 0 cleared when reorder_64=0.
    - A = {O[24:6], O[4:1], O[5], 1'b0} when reorder_64=1 (bits [5:1] rotated left by one within each 64-byte block).
    - Address sum is 25-bit and wraps modulo 2^25.
    - O increments after every byte.
    - When O+1 == length: odd-length SDRAM regions flush the pending byte as {8'h00,pending} with sdr_be=2'b01; then advance the region.
  - SDR_WAIT: hold sdr_req and all sdr_* outputs stable until sdr_ack.
    - Drop sdr_req in the cycle after ack; return to DATA or advance the region.
    - sdr_ack outside SDR_WAIT is ignored.
  - Region advance: region_idx+1; HDR, or DONE after the last region.
  - DONE: load_done=1; stays until the next rising edge of ioctl_download.
- ioctl_wait:
  - Rises in the cycle after the accepting byte that causes an SDRAM write.
  - Falls in the same cycle sdr_req falls.
  - 0 at all other times.
- ioctl_download falling mid-load:
  - If in SDR_WAIT: finish the handshake, then IDLE.
  - Otherwise: IDLE immediately.
  - load_done stays 0 and a partial pending byte is discarded.
- ioctl_wr while ioctl_download=0 is ignored.
- Throughput: one BRAM byte per ioctl_wr; at most one SDRAM word in flight.

Test Plan:
- CPU region, length 4, data 11 22 33 44, ack 2 cycles after each req:
  - Expect writes addr 0x000000 data 0x2211 be 11, then addr 0x000002 data 0x4433 be 11.
  - ioctl_wait high exactly while each req is pending.
- Sprite region (reorder_64), 64 bytes with byte k = k:
  - Expect the word at offset 0x20 written to 0x100002 with data 0x2120.
  - Expect offset 0x02 written to 0x100004.
- Odd-length BG A region of 3 bytes AA BB CC:
  - Expect 0x200000 data 0xBBAA be 11, then 0x200002 data 0x00CC be 01.
- Regions 0–3 with length 0, MCU length 2 (5A A5), samples length 1 (77):
  - Expect bram_wr with cs 01 at addr 0 and 1 with data 5A, A5.
  - Expect cs 10 at addr 0 with data 77.
  - load_done=1 and region_idx=5.
- ioctl_download dropped while sdr_req is high:
  - Req held until ack, then IDLE, load_done=0.
  - A new download restarts at region 0 with offset 0.
- reset_n low for one cycle during DATA:
  - Next cycle all outputs 0 and state IDLE.
  - sdr_req drops without waiting for ack.

Source files
------------

// File: rtl/m72_rom_loader_if.sv
`default_nettype none
// ============================================================================
// m72_rom_loader_if : ioctl download, SDRAM write and BRAM write bundle
// Revision: 1.0
// ============================================================================
interface m72_rom_loader_if #(
  parameter int BRAM_ADDR_W = 20
) ();
  logic                   ioctl_download;
  logic                   ioctl_wr;
  logic [7:0]             ioctl_dout;
  logic                   ioctl_wait;
  logic [24:0]            sdr_addr;
  logic [15:0]            sdr_data;
  logic [1:0]             sdr_be;
  logic                   sdr_req;
  logic                   sdr_ack;
  logic [BRAM_ADDR_W-1:0] bram_addr;
  logic [7:0]             bram_data;
  logic [1:0]             bram_cs;
  logic                   bram_wr;

  modport master (
    input  ioctl_download, ioctl_wr, ioctl_dout, sdr_ack,
    output ioctl_wait, sdr_addr, sdr_data, sdr_be, sdr_req,
    output bram_addr, bram_data, bram_cs, bram_wr
  );

  modport slave (
    output ioctl_download, ioctl_wr, ioctl_dout, sdr_ack,
    input  ioctl_wait, sdr_addr, sdr_data, sdr_be, sdr_req,
    input  bram_addr, bram_data, bram_cs, bram_wr
  );
endinterface
`default_nettype wire

// File: rtl/m72_rom_loader.sv
`default_nettype none
// ============================================================================
// m72_rom_loader : splits the ioctl ROM stream into SDRAM words / BRAM bytes
// Revision: 1.0
// ============================================================================
package m72_pkg;
  typedef struct packed {
    logic [24:0] base_addr;
    logic [1:0]  bram_cs;
    logic        reorder_64;
  } region_t;

  // CPU ROM, sprite, BG A, BG B, MCU, samples; bram_cs==0 selects SDRAM
  localparam region_t [0:5] LOAD_REGIONS = {
    {25'h0000000, 2'b00, 1'b0},
    {25'h0100000, 2'b00, 1'b1},
    {25'h0200000, 2'b00, 1'b0},
    {25'h0300000, 2'b00, 1'b0},
    {25'h0000000, 2'b01, 1'b0},
    {25'h0000000, 2'b10, 1'b0}
  };
endpackage

module m72_rom_loader
  import m72_pkg::*;
#(
  parameter int NUM_REGIONS = 6,
  parameter int BRAM_ADDR_W = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  m72_rom_loader_if.master bus,
  output logic [2:0]       region_idx,
  output logic             load_done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_HDR      = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
  localparam logic [2:0] S_SDR_WAIT = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [2:0]             region_q, region_d;
  logic [24:0]            len_q, len_d;
  logic [1:0]             hdr_cnt_q, hdr_cnt_d;
  logic [24:0]            offset_q, offset_d;
  logic [7:0]             pending_q, pending_d;
  logic                   last_q, last_d;
  logic                   abort_q, abort_d;
  logic                   dl_prev_q, dl_prev_d;
  logic [24:0]            sdr_addr_q, sdr_addr_d;
  logic [15:0]            sdr_data_q, sdr_data_d;
  logic [1:0]             sdr_be_q, sdr_be_d;
  logic                   sdr_req_q, sdr_req_d;
  logic [BRAM_ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [7:0]             bram_data_q, bram_data_d;
  logic [1:0]             bram_cs_q, bram_cs_d;
  logic                   bram_wr_q, bram_wr_d;
  logic                   load_done_q, load_done_d;

  region_t     cur_region;
  logic        is_sdram;
  logic        rise;
  logic        byte_acc;
  logic [24:0] off_inc;
  logic        last_byte;
  logic [24:0] hdr_len;
  logic [24:0] word_off;
  logic        sdr_issue;
  logic        bram_issue;
  logic        last_region;
  logic        advance;

  assign cur_region  = LOAD_REGIONS[region_q];
  assign is_sdram    = (cur_region.bram_cs == 2'b00);
  assign rise        = bus.ioctl_download && !dl_prev_q;
  assign byte_acc    = (state_q == S_DATA) && bus.ioctl_download && bus.ioctl_wr;
  assign off_inc     = offset_q + 25'd1;
  assign last_byte   = (off_inc == len_q);
  assign hdr_len     = {len_q[16:0], bus.ioctl_dout};
  assign last_region = (region_q == 3'(NUM_REGIONS - 1));
  // 64-byte reorder rotates word-address bits [5:1] left by one
  assign word_off    = cur_region.reorder_64 ?
                       {offset_q[24:6], offset_q[4:1], offset_q[5], 1'b0} :
                       {offset_q[24:1], 1'b0};
  // an odd offset completes a word; a final even offset flushes a half word
  assign sdr_issue   = byte_acc && is_sdram && (offset_q[0] || last_byte);
  assign bram_issue  = byte_acc && !is_sdram;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      region_q    <= 3'd0;
      len_q       <= 25'd0;
      hdr_cnt_q   <= 2'd0;
      offset_q    <= 25'd0;
      pending_q   <= 8'd0;
      last_q      <= 1'b0;
      abort_q     <= 1'b0;
      dl_prev_q   <= 1'b0;
      sdr_addr_q  <= 25'd0;
      sdr_data_q  <= 16'd0;
      sdr_be_q    <= 2'd0;
      sdr_req_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_data_q <= 8'd0;
      bram_cs_q   <= 2'd0;
      bram_wr_q   <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      region_q    <= region_d;
      len_q       <= len_d;
      hdr_cnt_q   <= hdr_cnt_d;
      offset_q    <= offset_d;
      pending_q   <= pending_d;
      last_q      <= last_d;
      abort_q     <= abort_d;
      dl_prev_q   <= dl_prev_d;
      sdr_addr_q  <= sdr_addr_d;
      sdr_data_q  <= sdr_data_d;
      sdr_be_q    <= sdr_be_d;
      sdr_req_q   <= sdr_req_d;
      bram_addr_q <= bram_addr_d;
      bram_data_q <= bram_data_d;
      bram_cs_q   <= bram_cs_d;
      bram_wr_q   <= bram_wr_d;
      load_done_q <= load_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    len_d     = len_q;
    hdr_cnt_d = hdr_cnt_q;
    offset_d  = offset_q;
    pending_d = pending_q;
    last_d    = last_q;
    abort_d   = abort_q;
    dl_prev_d = bus.ioctl_download;
    advance   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (rise) begin
          region_d  = 3'd0;
          hdr_cnt_d = 2'd0;
          abort_d   = 1'b0;
          pending_d = 8'd0;
          state_d   = S_HDR;
        end
      end
      S_HDR: begin
        if (!bus.ioctl_download) begin
          state_d = S_IDLE;
        end else if (bus.ioctl_wr) begin
          len_d     = hdr_len;
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            if (hdr_len == 25'd0) begin
              advance = 1'b1;
            end else begin
              offset_d = 25'd0;
              state_d  = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (!bus.ioctl_download) begin
          pending_d = 8'd0;
          state_d   = S_IDLE;
        end else if (bus.ioctl_wr) begin
          offset_d = off_inc;
          if (is_sdram && !offset_q[0]) begin
            pending_d = bus.ioctl_dout;
          end
          if (sdr_issue) begin
            last_d  = last_byte;
            state_d = S_SDR_WAIT;
          end else if (last_byte) begin
            advance = 1'b1;
          end
        end
      end
      S_SDR_WAIT: begin
        abort_d = abort_q || !bus.ioctl_download;
        if (bus.sdr_ack) begin
          if (abort_q || !bus.ioctl_download) begin
            abort_d   = 1'b0;
            pending_d = 8'd0;
            state_d   = S_IDLE;
          end else if (last_q) begin
            advance = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (last_region) begin
        state_d = S_DONE;
      end else begin
        region_d  = region_q + 3'd1;
        hdr_cnt_d = 2'd0;
        state_d   = S_HDR;
      end
    end
  end

  always_comb begin
    sdr_addr_d  = sdr_addr_q;
    sdr_data_d  = sdr_data_q;
    sdr_be_d    = sdr_be_q;
    sdr_req_d   = sdr_req_q;
    bram_addr_d = bram_addr_q;
    bram_data_d = bram_data_q;
    bram_cs_d   = bram_cs_q;
    bram_wr_d   = 1'b0;
    load_done_d = (state_d == S_DONE);

    if (sdr_issue) begin
      sdr_req_d  = 1'b1;
      sdr_addr_d = cur_region.base_addr + word_off;
      if (offset_q[0]) begin
        sdr_data_d = {bus.ioctl_dout, pending_q};
        sdr_be_d   = 2'b11;
      end else begin
        sdr_data_d = {8'h00, bus.ioctl_dout};
        sdr_be_d   = 2'b01;
      end
    end else if ((state_q == S_SDR_WAIT) && bus.sdr_ack) begin
      sdr_req_d = 1'b0;
    end

    if (bram_issue) begin
      bram_wr_d   = 1'b1;
      bram_addr_d = offset_q[BRAM_ADDR_W-1:0];
      bram_data_d = bus.ioctl_dout;
      bram_cs_d   = cur_region.bram_cs;
    end
  end

  assign bus.ioctl_wait = sdr_req_q;
  assign bus.sdr_addr   = sdr_addr_q;
  assign bus.sdr_data   = sdr_data_q;
  assign bus.sdr_be     = sdr_be_q;
  assign bus.sdr_req    = sdr_req_q;
  assign bus.bram_addr  = bram_addr_q;
  assign bus.bram_data  = bram_data_q;
  assign bus.bram_cs    = bram_cs_q;
  assign bus.bram_wr    = bram_wr_q;
  assign region_idx     = region_q;
  assign load_done      = load_done_q;

endmodule
`default_nettype wire

// File: tb/tb_m72_rom_loader.sv
`default_nettype none
// ============================================================================
// tb_m72_rom_loader : vector table, hand sequences and randomized downloads
// Revision: 1.0
// ============================================================================
module tb_m72_rom_loader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] region_idx;
  logic       load_done;

  m72_rom_loader_if #(.BRAM_ADDR_W(20)) bus ();

  m72_rom_loader #(.NUM_REGIONS(6), .BRAM_ADDR_W(20)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.master),
    .region_idx(region_idx),
    .load_done (load_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          rg;
    int          len;
    logic [7:0]  d0, d1, d2, d3;
    int          nsdr;
    int          nbram;
    logic [42:0] w0, w1;
  } vec_t;

  // board map as the loader is expected to see it
  logic [24:0] tb_base [6] = '{25'h0, 25'h100000, 25'h200000, 25'h300000, 25'h0, 25'h0};
  logic [1:0]  tb_cs   [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
  logic        tb_reo  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  int          lens [6];
  logic [7:0]  rdata [6][64];
  logic [42:0] got_sdr[$], got_bram[$], exp_sdr[$], exp_bram[$];
  int          wait_err = 0, stab_err = 0;
  int          sdr_mark, bram_mark, werr_mark, serr_mark;
  int          n_vec = 0, n_miss = 0;
  int          ack_dly = 1, gap_max = 0;
  logic        ack_en = 1'b1;
  logic        req_prev = 1'b0;
  logic [42:0] hold_w = '0;
  int          ack_cnt = 0;

  // observer and SDRAM acknowledge responder, all on the falling edge
  always @(negedge clk) begin
    if (bus.sdr_req && !req_prev)
      got_sdr.push_back({bus.sdr_addr, bus.sdr_data, bus.sdr_be});
    if (bus.sdr_req && req_prev && ({bus.sdr_addr, bus.sdr_data, bus.sdr_be} != hold_w))
      stab_err++;
    if (bus.ioctl_wait != bus.sdr_req)
      wait_err++;
    if (bus.bram_wr)
      got_bram.push_back({13'd0, bus.bram_cs, bus.bram_addr, bus.bram_data});
    req_prev = bus.sdr_req;
    hold_w   = {bus.sdr_addr, bus.sdr_data, bus.sdr_be};
    if (bus.sdr_ack === 1'b1) begin
      bus.sdr_ack = 1'b0;
    end else if (ack_en && bus.sdr_req) begin
      if (ack_cnt >= ack_dly) begin
        bus.sdr_ack = 1'b1;
        ack_cnt     = 0;
      end else begin
        bus.sdr_ack = 1'b0;
        ack_cnt++;
      end
    end else begin
      bus.sdr_ack = 1'b0;
      ack_cnt     = 0;
    end
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic mark();
    sdr_mark  = got_sdr.size();
    bram_mark = got_bram.size();
    werr_mark = wait_err;
    serr_mark = stab_err;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(0, gap_max) + 1) @(negedge clk);
    while (bus.ioctl_wait && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_vec++;
      n_miss++;
      $display("FAIL ioctl_wait_timeout: wait still %0d after %0d cycles", bus.ioctl_wait, n);
    end
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_dout = b;
    @(negedge clk);
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic send_hdr(input int len);
    logic [31:0] l;
    l = len;
    send_byte(l[31:24]);
    send_byte(l[23:16]);
    send_byte(l[15:8]);
    send_byte(l[7:0]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.ioctl_wait || bus.sdr_req) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_vec++;
      n_miss++;
      $display("FAIL idle_timeout: sdr_req %0d still pending", bus.sdr_req);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_download();
    @(negedge clk);
    bus.ioctl_download = 1'b1;
    repeat (2) @(negedge clk);
    check("load_done_clear_on_start", load_done, 0);
    for (int r = 0; r < 6; r++) begin
      send_hdr(lens[r]);
      for (int i = 0; i < lens[r]; i++) send_byte(rdata[r][i]);
    end
    wait_idle();
  endtask

  task automatic end_download();
    bus.ioctl_download = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // expected writes straight from the stream format: words pair up bytes
  // (low byte first), odd tails flush alone, BRAM bytes go out one by one
  task automatic build_model();
    exp_sdr.delete();
    exp_bram.delete();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < lens[r]; i++) begin
        logic [24:0] a;
        int off, w;
        if (tb_cs[r] == 2'b00) begin
          if (i % 2 == 0) begin
            off = i;
            if (tb_reo[r]) begin
              w   = (i / 2) % 32;
              off = (i / 64) * 64 + (((w * 2) % 32) + (w / 16)) * 2;
            end
            a = tb_base[r] + 25'(off);
            if (i + 1 < lens[r]) exp_sdr.push_back({a, rdata[r][i+1], rdata[r][i], 2'b11});
            else                 exp_sdr.push_back({a, 8'h00, rdata[r][i], 2'b01});
          end
        end else begin
          exp_bram.push_back({13'd0, tb_cs[r], 20'(i), rdata[r][i]});
        end
      end
    end
  endtask

  task automatic compare_model(input string tag);
    build_model();
    check({tag, " sdr_count"}, got_sdr.size() - sdr_mark, exp_sdr.size());
    for (int i = 0; i < exp_sdr.size() && sdr_mark + i < got_sdr.size(); i++)
      check({tag, " sdr_word"}, got_sdr[sdr_mark+i], exp_sdr[i]);
    check({tag, " bram_count"}, got_bram.size() - bram_mark, exp_bram.size());
    for (int i = 0; i < exp_bram.size() && bram_mark + i < got_bram.size(); i++)
      check({tag, " bram_byte"}, got_bram[bram_mark+i], exp_bram[i]);
    check({tag, " wait_tracks_req"}, wait_err - werr_mark, 0);
    check({tag, " req_outputs_stable"}, stab_err - serr_mark, 0);
  endtask

  task automatic clear_stream();
    for (int r = 0; r < 6; r++) begin
      lens[r] = 0;
      for (int i = 0; i < 64; i++) rdata[r][i] = 8'h00;
    end
  endtask

  task automatic start_r0_two_bytes();
    clear_stream();
    lens[0] = 4;
    @(negedge clk);
    bus.ioctl_download = 1'b1;
    send_hdr(4);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
  endtask

  vec_t vt [6];

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_dout     = 8'h00;

    vt[0] = '{0, 4, 8'h11, 8'h22, 8'h33, 8'h44, 2, 0,
              {25'h000000, 16'h2211, 2'b11}, {25'h000002, 16'h4433, 2'b11}};
    vt[1] = '{1, 4, 8'h00, 8'h01, 8'h02, 8'h03, 2, 0,
              {25'h100000, 16'h0100, 2'b11}, {25'h100004, 16'h0302, 2'b11}};
    vt[2] = '{2, 3, 8'hAA, 8'hBB, 8'hCC, 8'h00, 2, 0,
              {25'h200000, 16'hBBAA, 2'b11}, {25'h200002, 16'h00CC, 2'b01}};
    vt[3] = '{3, 1, 8'hE7, 8'h00, 8'h00, 8'h00, 1, 0,
              {25'h300000, 16'h00E7, 2'b01}, 43'd0};
    vt[4] = '{4, 2, 8'h5A, 8'hA5, 8'h00, 8'h00, 0, 2,
              {13'd0, 2'b01, 20'h0, 8'h5A}, {13'd0, 2'b01, 20'h1, 8'hA5}};
    vt[5] = '{5, 1, 8'h77, 8'h00, 8'h00, 8'h00, 0, 1,
              {13'd0, 2'b10, 20'h0, 8'h77}, 43'd0};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset sdr_req", bus.sdr_req, 0);
    check("reset ioctl_wait", bus.ioctl_wait, 0);
    check("reset load_done", load_done, 0);
    check("reset region_idx", region_idx, 0);
    check("reset bram_wr", bus.bram_wr, 0);

    // single-region downloads with hand-computed expected writes
    for (int v = 0; v < 6; v++) begin
      clear_stream();
      lens[vt[v].rg] = vt[v].len;
      rdata[vt[v].rg][0] = vt[v].d0;
      rdata[vt[v].rg][1] = vt[v].d1;
      rdata[vt[v].rg][2] = vt[v].d2;
      rdata[vt[v].rg][3] = vt[v].d3;
      ack_dly = 2;
      mark();
      run_download();
      check("vec sdr_count", got_sdr.size() - sdr_mark, vt[v].nsdr);
      check("vec bram_count", got_bram.size() - bram_mark, vt[v].nbram);
      if (vt[v].nsdr > 0 && got_sdr.size() > sdr_mark)
        check("vec sdr_w0", got_sdr[sdr_mark], vt[v].w0);
      if (vt[v].nsdr > 1 && got_sdr.size() > sdr_mark + 1)
        check("vec sdr_w1", got_sdr[sdr_mark+1], vt[v].w1);
      if (vt[v].nbram > 0 && got_bram.size() > bram_mark)
        check("vec bram_w0", got_bram[bram_mark], vt[v].w0);
      if (vt[v].nbram > 1 && got_bram.size() > bram_mark + 1)
        check("vec bram_w1", got_bram[bram_mark+1], vt[v].w1);
      check("vec wait_tracks_req", wait_err - werr_mark, 0);
      check("vec load_done", load_done, 1);
      check("vec region_idx", region_idx, 5);
      end_download();
      check("vec load_done_sticky", load_done, 1);
    end

    // sprite region, 64 bytes k=k, 64-byte reorder
    clear_stream();
    lens[1] = 64;
    for (int i = 0; i < 64; i++) rdata[1][i] = 8'(i);
    mark();
    run_download();
    compare_model("sprite64");
    if (got_sdr.size() > sdr_mark + 16) begin
      check("sprite off20 addr", got_sdr[sdr_mark+16][42:18], 25'h100002);
      check("sprite off20 data", got_sdr[sdr_mark+16][17:2], 16'h2120);
      check("sprite off02 addr", got_sdr[sdr_mark+1][42:18], 25'h100004);
    end
    end_download();

    // both BRAM regions in one download
    clear_stream();
    lens[4] = 2; rdata[4][0] = 8'h5A; rdata[4][1] = 8'hA5;
    lens[5] = 1; rdata[5][0] = 8'h77;
    mark();
    run_download();
    compare_model("bram_pair");
    check("bram_pair load_done", load_done, 1);
    check("bram_pair region_idx", region_idx, 5);
    end_download();

    // download dropped while a request is outstanding
    ack_en = 1'b0;
    mark();
    start_r0_two_bytes();
    bus.ioctl_download = 1'b0;
    repeat (5) @(negedge clk);
    check("drop req_held", bus.sdr_req, 1);
    check("drop wait_held", bus.ioctl_wait, 1);
    ack_en = 1'b1;
    wait_idle();
    check("drop load_done", load_done, 0);
    check("drop one_word", got_sdr.size() - sdr_mark, 1);
    if (got_sdr.size() > sdr_mark)
      check("drop word", got_sdr[sdr_mark], {25'h0, 16'h2211, 2'b11});
    send_byte(8'h33);
    send_byte(8'h44);
    repeat (3) @(negedge clk);
    check("drop wr_ignored", got_sdr.size() - sdr_mark, 1);
    clear_stream();
    lens[0] = 4;
    for (int i = 0; i < 4; i++) rdata[0][i] = 8'($urandom);
    mark();
    run_download();
    compare_model("restart");
    end_download();

    // one-cycle reset with a request outstanding
    ack_en = 1'b0;
    start_r0_two_bytes();
    check("pre_reset req", bus.sdr_req, 1);
    reset_n = 1'b0;
    bus.ioctl_download = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst sdr_req", bus.sdr_req, 0);
    check("rst ioctl_wait", bus.ioctl_wait, 0);
    check("rst sdr_addr", bus.sdr_addr, 0);
    check("rst sdr_data", bus.sdr_data, 0);
    check("rst sdr_be", bus.sdr_be, 0);
    check("rst bram", {bus.bram_wr, bus.bram_cs, bus.bram_addr, bus.bram_data}, 0);
    check("rst region_idx", region_idx, 0);
    check("rst load_done", load_done, 0);
    ack_en = 1'b1;
    repeat (5) @(negedge clk);
    check("rst req_stays_low", bus.sdr_req, 0);

    // randomized multi-region downloads against the stream model
    for (int t = 0; t < 10; t++) begin
      clear_stream();
      for (int r = 0; r < 6; r++) begin
        lens[r] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
        for (int i = 0; i < 64; i++) rdata[r][i] = 8'($urandom);
      end
      ack_dly = $urandom_range(0, 3);
      gap_max = $urandom_range(0, 2);
      mark();
      run_download();
      compare_model("random");
      check("random load_done", load_done, 1);
      check("random region_idx", region_idx, 5);
      end_download();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
